// File: rtl/um1_loader.sv
// Serial microcode loader: shifts address/word frames in from a host link
// and writes them into the sequencer's microprogram memory. Option: UM1_LOADER_PARITY_EN.
module um1_loader (
  input  logic        ck,
  input  logic        rst_n,
  input  logic        sen,
  input  logic        sck,
  input  logic        sdi,
  input  logic        ec,
  output logic [4:0]  wa,
  output logic [12:0] wdat,
  output logic        we,
  output logic        hold,
  output logic        err,
  output logic [5:0]  nw
);

`ifdef UM1_LOADER_PARITY_EN
  localparam int NB = 19;
`else
  localparam int NB = 18;
`endif
  localparam logic [4:0] NB_W = 5'(NB);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, WRITE} state_t;

  state_t state_q, state_d;

  logic [2:0]    sen_sync_q, sen_sync_d;
  logic [2:0]    sck_sync_q, sck_sync_d;
  logic [2:0]    sdi_sync_q, sdi_sync_d;
  logic [NB-1:0] sr_q, sr_d;
  logic [4:0]    bc_q, bc_d;
  logic [4:0]    wa_q, wa_d;
  logic [12:0]   wdat_q, wdat_d;
  logic          err_q, err_d;
  logic [5:0]    nw_q, nw_d;

  logic sen_fall, sen_rise, sck_rise, sdi_al;
  logic frame_ok;

  // stage 2 vs stage 3 gives the edge; sdi stage 2 lines up with it
  assign sen_fall = ~sen_sync_q[1] &  sen_sync_q[2];
  assign sen_rise =  sen_sync_q[1] & ~sen_sync_q[2];
  assign sck_rise =  sck_sync_q[1] & ~sck_sync_q[2];
  assign sdi_al   =  sdi_sync_q[1];

`ifdef UM1_LOADER_PARITY_EN
  assign frame_ok = (bc_q == NB_W) && !(^sr_q);
`else
  assign frame_ok = (bc_q == NB_W);
`endif

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sen_fall) state_d = SHIFT;
      SHIFT:   if (sen_rise) state_d = CHECK;
      CHECK:   state_d = frame_ok ? WRITE : IDLE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    we   = (state_q == WRITE);
    hold = (state_q != IDLE) || !sen_sync_q[1];
  end

  always_comb begin
    sen_sync_d = {sen_sync_q[1:0], sen};
    sck_sync_d = {sck_sync_q[1:0], sck};
    sdi_sync_d = {sdi_sync_q[1:0], sdi};
    sr_d       = sr_q;
    bc_d       = bc_q;
    wa_d       = wa_q;
    wdat_d     = wdat_q;
    err_d      = err_q;
    nw_d       = nw_q;
    if (state_q == IDLE && sen_fall) begin
      sr_d = '0;
      bc_d = '0;
    end
    if (state_q == SHIFT && sck_rise) begin
      sr_d = {sr_q[NB-2:0], sdi_al};
      if (bc_q != 5'd31) bc_d = bc_q + 5'd1;
    end
    if (state_q == CHECK && frame_ok) begin
      wa_d   = sr_q[NB-1 -: 5];
      wdat_d = sr_q[NB-6 -: 13];
    end
    if (state_q == CHECK && !frame_ok) err_d = 1'b1;
    else if (ec)                       err_d = 1'b0;
    if (state_q == WRITE && nw_q != 6'd63) nw_d = nw_q + 6'd1;
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      sen_sync_q <= 3'b111;
      sck_sync_q <= '0;
      sdi_sync_q <= '0;
      sr_q       <= '0;
      bc_q       <= '0;
      wa_q       <= '0;
      wdat_q     <= '0;
      err_q      <= 1'b0;
      nw_q       <= '0;
    end else begin
      sen_sync_q <= sen_sync_d;
      sck_sync_q <= sck_sync_d;
      sdi_sync_q <= sdi_sync_d;
      sr_q       <= sr_d;
      bc_q       <= bc_d;
      wa_q       <= wa_d;
      wdat_q     <= wdat_d;
      err_q      <= err_d;
      nw_q       <= nw_d;
    end
  end

  assign wa   = wa_q;
  assign wdat = wdat_q;
  assign err  = err_q;
  assign nw   = nw_q;

endmodule

// File: tb/tb_um1_loader.sv
// Directed, table-driven bench for um1_loader.
// Frames are driven with slow sck and checked for we/wa/wdat/err/nw.
module tb_um1_loader;

`ifdef UM1_LOADER_PARITY_EN
  localparam int NB = 19;
`else
  localparam int NB = 18;
`endif

  logic        ck = 1'b0;
  logic        rst_n, sen, sck, sdi, ec;
  logic [4:0]  wa;
  logic [12:0] wdat;
  logic        we, hold, err;
  logic [5:0]  nw;

  um1_loader dut (
    .ck(ck), .rst_n(rst_n), .sen(sen), .sck(sck), .sdi(sdi), .ec(ec),
    .wa(wa), .wdat(wdat), .we(we), .hold(hold), .err(err), .nw(nw)
  );

  always #5 ck = ~ck;

  int n_cmp = 0;
  int n_bad = 0;
  int we_cnt = 0;
  logic [4:0]  last_wa;
  logic [12:0] last_wdat;
  logic hold_at_we, hold_after_we, prev_we;
  logic hold_early;

  initial begin
    last_wa = '0; last_wdat = '0;
    hold_at_we = 1'b0; hold_after_we = 1'b1; prev_we = 1'b0;
  end

  always @(negedge ck) begin
    if (prev_we) hold_after_we = hold;
    if (we) begin
      we_cnt++;
      last_wa    = wa;
      last_wdat  = wdat;
      hold_at_we = hold;
    end
    prev_we = we;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ck);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NB-1:0] mk(input logic [4:0] a,
                                       input logic [12:0] w,
                                       input logic flip);
    logic [17:0] p;
    p = {a, w};
`ifdef UM1_LOADER_PARITY_EN
    return {p, (^p) ^ flip};
`else
    return p ^ {17'd0, flip};
`endif
  endfunction

  // n bits MSB first; bits past NB are zeros
  task automatic send(input logic [NB-1:0] f, input int n);
    sen = 1'b0;
    tick(3);
    hold_early = hold;
    tick(2);
    for (int k = 0; k < n; k++) begin
      sdi = (k < NB) ? f[NB-1-k] : 1'b0;
      tick(2);
      sck = 1'b1;
      tick(4);
      sck = 1'b0;
      tick(2);
    end
    tick(4);
    sen = 1'b1;
    tick(12);
  endtask

  typedef struct {
    int          nbits;
    logic [4:0]  addr;
    logic [12:0] word;
    logic        flip;
    logic        good;
  } vec_t;

  vec_t vq[$];

  initial begin
    int w0, nw0;
    vec_t v;
    rst_n = 1'b0; sen = 1'b1; sck = 1'b0; sdi = 1'b0; ec = 1'b0;
    tick(3);
    chk("rst_wa", 32'(wa), 0);
    chk("rst_wdat", 32'(wdat), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_hold", 32'(hold), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_nw", 32'(nw), 0);
    rst_n = 1'b1;
    tick(3);

    vq.push_back('{NB,      5'h03, 13'h1A5A, 1'b0, 1'b1});
    vq.push_back('{NB - 1,  5'h07, 13'h0F0F, 1'b0, 1'b0});
    vq.push_back('{NB + 1,  5'h07, 13'h0F0F, 1'b0, 1'b0});
    vq.push_back('{0,       5'h00, 13'h0000, 1'b0, 1'b0});
    vq.push_back('{33,      5'h1F, 13'h1FFF, 1'b0, 1'b0});
    vq.push_back('{NB,      5'h1E, 13'h0001, 1'b0, 1'b1});
    vq.push_back('{NB,      5'h11, 13'h1555, 1'b0, 1'b1});
`ifdef UM1_LOADER_PARITY_EN
    vq.push_back('{NB,      5'h11, 13'h1555, 1'b1, 1'b0});
`endif

    foreach (vq[i]) begin
      v   = vq[i];
      w0  = we_cnt;
      nw0 = int'(nw);
      send(mk(v.addr, v.word, v.flip), v.nbits);
      chk($sformatf("v%0d_hold_early", i), 32'(hold_early), 1);
      chk($sformatf("v%0d_we_cnt", i), 32'(we_cnt - w0), v.good ? 1 : 0);
      chk($sformatf("v%0d_err", i), 32'(err), v.good ? 0 : 1);
      chk($sformatf("v%0d_nw", i), 32'(nw), v.good ? nw0 + 1 : nw0);
      chk($sformatf("v%0d_hold_idle", i), 32'(hold), 0);
      if (v.good) begin
        chk($sformatf("v%0d_wa", i), 32'(wa), 32'(v.addr));
        chk($sformatf("v%0d_wdat", i), 32'(wdat), 32'(v.word));
        chk($sformatf("v%0d_hold_at_we", i), 32'(hold_at_we), 1);
        chk($sformatf("v%0d_hold_after_we", i), 32'(hold_after_we), 0);
      end
      ec = 1'b1;
      tick(1);
      ec = 1'b0;
      chk($sformatf("v%0d_err_clr", i), 32'(err), 0);
    end

    // sck activity with sen high must be ignored
    w0  = we_cnt;
    nw0 = int'(nw);
    sdi = 1'b1;
    for (int k = 0; k < 6; k++) begin
      sck = 1'b1;
      tick(4);
      chk("idle_hold", 32'(hold), 0);
      sck = 1'b0;
      tick(4);
    end
    sdi = 1'b0;
    tick(8);
    chk("idle_we", 32'(we_cnt - w0), 0);
    chk("idle_nw", 32'(nw), 32'(nw0));
    chk("idle_err", 32'(err), 0);

    // saturation of the written-word counter
    w0 = we_cnt;
    for (int i = 0; i < 64; i++)
      send(mk(5'(i), 13'(i * 37 + 5), 1'b0), NB);
    chk("sat_we_cnt", 32'(we_cnt - w0), 64);
    chk("sat_nw", 32'(nw), 63);
    chk("sat_wa", 32'(last_wa), 31);
    chk("sat_wdat", 32'(last_wdat), 32'(13'(63 * 37 + 5)));

    // reset in the middle of a frame
    w0 = we_cnt;
    sen = 1'b0;
    tick(5);
    for (int k = 0; k < 9; k++) begin
      sdi = k[0];
      tick(2);
      sck = 1'b1;
      tick(4);
      sck = 1'b0;
      tick(2);
    end
    rst_n = 1'b0;
    tick(1);
    chk("mid_rst_wa", 32'(wa), 0);
    chk("mid_rst_wdat", 32'(wdat), 0);
    chk("mid_rst_hold", 32'(hold), 0);
    chk("mid_rst_nw", 32'(nw), 0);
    sen = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(10);
    chk("mid_rst_no_we", 32'(we_cnt - w0), 0);
    send(mk(5'h0A, 13'h0BCD, 1'b0), NB);
    chk("post_rst_we", 32'(we_cnt - w0), 1);
    chk("post_rst_wa", 32'(wa), 32'h0A);
    chk("post_rst_wdat", 32'(wdat), 32'h0BCD);
    chk("post_rst_nw", 32'(nw), 1);
    chk("post_rst_err", 32'(err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
